// File: rtl/toy_lsu.sv
// toy_lsu: load/store unit in front of a zero-latency word memory, one request in flight.
// TOY_LSU_MISALIGN_EN: word-crossing accesses run as two memory beats; undefined rejects them with resp_err.
// state | meaning
// IDLE  | drive the first (or only) memory beat from the live request
// SPLIT | drive the second beat of a word-crossing access from latched fields
module toy_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [4:0]            req_tag,
  output logic                  resp_vld,
  input  logic                  resp_rdy,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [4:0]            resp_tag,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [3:0]            mem_wr_byte_en,
  output logic                  mem_wr_en
);
  localparam int WW = ADDR_WIDTH - 2;

  logic          r_resp_vld;
  logic [31:0]   r_resp_data;
  logic [4:0]    r_resp_tag;
  logic          r_resp_err;

  logic [1:0]    w_off;
  logic [2:0]    w_n;
  logic [3:0]    w_mask_base;
  logic          w_split;
  logic [WW-1:0] w_word;
  logic [3:0]    w_be_lo;
  logic [31:0]   w_wd_lo;
  logic          w_in_split;
  logic          w_accept;
  logic [31:0]   w_ld_single;

  // Shift the two-word window down to the addressed byte, then size and extend.
  function automatic logic [31:0] f_extract(input logic [63:0] d, input logic [1:0] off,
                                            input logic [1:0] size, input logic uns);
    logic [31:0] s;
    s = 32'(d >> {off, 3'b000});
    case (size)
      2'd0:    f_extract = {{24{~uns & s[7]}}, s[7:0]};
      2'd1:    f_extract = {{16{~uns & s[15]}}, s[15:0]};
      default: f_extract = s;
    endcase
  endfunction

  assign w_off  = req_addr[1:0];
  assign w_word = req_addr[ADDR_WIDTH-1:2];

  always_comb begin
    w_n         = 3'd4;
    w_mask_base = 4'hF;
    case (req_size)
      2'd0:    begin w_n = 3'd1; w_mask_base = 4'h1; end
      2'd1:    begin w_n = 3'd2; w_mask_base = 4'h3; end
      default: begin end
    endcase
  end

  assign w_split     = ({1'b0, w_off} + w_n) > 3'd4;
  assign w_ld_single = f_extract({32'd0, mem_rd_data}, w_off, req_size, req_unsigned);
  assign req_rdy     = rst_n & ~w_in_split & (~r_resp_vld | resp_rdy);
  assign w_accept    = req_vld & req_rdy;

`ifdef TOY_LSU_MISALIGN_EN
  typedef enum logic {IDLE, SPLIT} state_t;

  state_t        r_state;
  logic [WW-1:0] r_word_hi;
  logic [3:0]    r_be_hi;
  logic [31:0]   r_wd_hi;
  logic [31:0]   r_lo;
  logic          r_wr;
  logic          r_uns;
  logic [1:0]    r_size;
  logic [1:0]    r_off;
  logic [4:0]    r_tag;

  logic [7:0]    w_mask8;
  logic [63:0]   w_wd64;
  logic [WW-1:0] w_word_nxt;

  assign w_mask8    = {4'd0, w_mask_base} << w_off;
  assign w_wd64     = {32'd0, req_wdata} << {w_off, 3'b000};
  assign w_word_nxt = w_word + {{(WW-1){1'b0}}, 1'b1};
  assign w_be_lo    = w_mask8[3:0];
  assign w_wd_lo    = w_wd64[31:0];
  assign w_in_split = (r_state == SPLIT);

  always_comb begin
    if (w_in_split) begin
      mem_addr       = {2'b00, r_word_hi};
      mem_wr_en      = rst_n & r_wr;
      mem_wr_byte_en = r_be_hi;
      mem_wr_data    = r_wd_hi;
    end else begin
      mem_addr       = {2'b00, w_word};
      mem_wr_en      = w_accept & req_wr;
      mem_wr_byte_en = w_be_lo;
      mem_wr_data    = w_wd_lo;
    end
  end
`else
  assign w_be_lo        = w_mask_base << w_off;
  assign w_wd_lo        = req_wdata << {w_off, 3'b000};
  assign w_in_split     = 1'b0;
  assign mem_addr       = {2'b00, w_word};
  assign mem_wr_en      = w_accept & req_wr & ~w_split;
  assign mem_wr_byte_en = w_be_lo;
  assign mem_wr_data    = w_wd_lo;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_vld  <= 1'b0;
      r_resp_data <= 32'd0;
      r_resp_tag  <= 5'd0;
      r_resp_err  <= 1'b0;
`ifdef TOY_LSU_MISALIGN_EN
      r_state     <= IDLE;
      r_word_hi   <= '0;
      r_be_hi     <= 4'd0;
      r_wd_hi     <= 32'd0;
      r_lo        <= 32'd0;
      r_wr        <= 1'b0;
      r_uns       <= 1'b0;
      r_size      <= 2'd0;
      r_off       <= 2'd0;
      r_tag       <= 5'd0;
`endif
    end else begin
      if (r_resp_vld && resp_rdy)
        r_resp_vld <= 1'b0;
`ifdef TOY_LSU_MISALIGN_EN
      if (r_state == SPLIT) begin
        r_state     <= IDLE;
        r_resp_vld  <= 1'b1;
        r_resp_data <= r_wr ? 32'd0 : f_extract({mem_rd_data, r_lo}, r_off, r_size, r_uns);
        r_resp_tag  <= r_tag;
        r_resp_err  <= 1'b0;
      end else
`endif
      if (w_accept) begin
        if (w_split) begin
`ifdef TOY_LSU_MISALIGN_EN
          r_state   <= SPLIT;
          r_word_hi <= w_word_nxt;
          r_be_hi   <= w_mask8[7:4];
          r_wd_hi   <= w_wd64[63:32];
          r_lo      <= mem_rd_data;
          r_wr      <= req_wr;
          r_uns     <= req_unsigned;
          r_size    <= req_size;
          r_off     <= w_off;
          r_tag     <= req_tag;
`else
          r_resp_vld  <= 1'b1;
          r_resp_data <= 32'd0;
          r_resp_tag  <= req_tag;
          r_resp_err  <= 1'b1;
`endif
        end else begin
          r_resp_vld  <= 1'b1;
          r_resp_data <= req_wr ? 32'd0 : w_ld_single;
          r_resp_tag  <= req_tag;
          r_resp_err  <= 1'b0;
        end
      end
    end
  end

  assign resp_vld  = r_resp_vld;
  assign resp_data = r_resp_data;
  assign resp_tag  = r_resp_tag;
  assign resp_err  = r_resp_err;

endmodule

// File: doc/toy_lsu.md
TOY_LSU -- requirements
Module: toy_lsu

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width of the request port and width of mem_addr.
REQ-002 SHALL have parameter DATA_WIDTH, default 32; only 32 is supported.
REQ-003 SHALL have ports as listed:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_vld  in  1  request valid.
- req_rdy  out  1  request ready.
- req_wr  in  1  1=store, 0=load.
- req_size  in  2  0=byte, 1=half, 2=word; 3 is treated as word.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_tag  in  5  opaque tag returned with the response.
- resp_vld  out  1  response valid.
- resp_rdy  in  1  response ready.
- resp_data  out  32  load result; 0 for stores.
- resp_tag  out  5  tag of the request.
- resp_err  out  1  misaligned access rejected.
- mem_addr  out  ADDR_WIDTH  word address to the 0-delay memory.
- mem_rd_data  in  32  combinational read data.
- mem_wr_data  out  32  write data.
- mem_wr_byte_en  out  4  byte enables.
- mem_wr_en  out  1  write strobe; memory commits on clk edge.

Function
REQ-004 SHALL accept a request on a rising clk edge where req_vld and req_rdy are both 1.
REQ-005 SHALL drive req_rdy = rst_n & (state==IDLE) & (!resp_vld | resp_rdy).
REQ-006 Definitions: off = req_addr[1:0]; n = 1/2/4 bytes from req_size; an access is split when off+n > 4.
REQ-007 Byte mask: mask8 = ((1<<n)-1)<<off. Write data: wd64 = req_wdata<<(8*off). Low halves go to word W, high halves go to word W+1.
REQ-008 Word address: W = req_addr>>2. W+1 wraps modulo 2^(ADDR_WIDTH-2).
REQ-009 FSM states SHALL be IDLE and SPLIT.
- IDLE: mem_addr = W from live request inputs.
- IDLE, non-split accept: response register loads; stay IDLE.
- IDLE, split accept: latch request, W+1, mask8[7:4], wd64[63:32], and mem_rd_data (low word); go to SPLIT.
- SPLIT: mem_addr = W+1; the next edge loads the response; return to IDLE unconditionally.
REQ-010 Store write strobe:
- In IDLE, mem_wr_en = accept & req_wr; mem_wr_byte_en = mask8[3:0]; mem_wr_data = wd64[31:0].
- In SPLIT, mem_wr_en = latched store bit; byte enables and data come from the latched high halves.
- A byte-enable nibble of 0 SHALL never be driven with mem_wr_en=1.
REQ-011 Load result = ({hi,lo} >> 8*off) truncated to n bytes, then sign- or zero-extended to 32 bits. For non-split loads, hi = 0 and lo = mem_rd_data.
REQ-012 Latency: resp_vld rises 1 cycle after accept (non-split) or 2 cycles after accept (split).
REQ-013 resp_vld, resp_data, resp_tag and resp_err SHALL be held stable until resp_rdy=1. Response consumption and a new accept in the same edge SHALL both occur.
REQ-014 Store responses SHALL carry resp_data=0, resp_err=0 and the request tag.
REQ-015 mem_wr_en SHALL be 0 whenever rst_n=0.

Reset
REQ-016 On rst_n low, asynchronously: state=IDLE, resp_vld=0, resp_data=0, resp_tag=0, resp_err=0, all latched split fields=0.
REQ-017 Reset during SPLIT SHALL abandon the second access with no write. A first-half store already committed remains in memory.

Configuration
REQ-018 Macro TOY_LSU_MISALIGN_EN.
- Defined: split accesses SHALL follow REQ-009.
- Undefined: a split request is accepted and completes in 1 cycle with resp_err=1, resp_data=0, and mem_wr_en=0. SPLIT state and its latches SHALL not be instantiated.

Verification
REQ-019 Memory word 4 (byte addr 0x10) = 0x8899AABB; lw 0x10 -> resp_data 0x8899AABB 1 cycle after accept.
REQ-020 Same word; lb 0x11 signed -> 0xFFFFFFAA; lbu 0x11 -> 0x000000AA; lh 0x12 signed -> 0xFFFF8899.
REQ-021 sh 0x12, wdata 0x00001234 -> one write, mem_addr=4, be=4'b1100, wr_data 0x12340000; word 4 becomes 0x1234AABB.
REQ-022 With MISALIGN_EN: sw 0x13, wdata 0xDDCCBBAA -> write word 4 be=1000 data 0xAA000000, then word 5 be=0111 data 0x00DDCCBB; lw 0x13 returns 0xDDCCBBAA 2 cycles after accept. Without MISALIGN_EN: resp_err=1 and no write.
REQ-023 Hold resp_rdy=0 for 3 cycles -> resp fields stable, req_rdy=0. Raise resp_rdy with a new req_vld -> both handshakes occur on the same edge.
REQ-024 Assert rst_n=0 during SPLIT of a split store -> only the first write occurs, resp_vld=0, and the next request is accepted normally.
